local_input_fifo: RTL and testbench

- Router local-port input buffer; sits directly downstream of each PE traffic injector.
- Accepts 32-bit packets over the Req/Gnt/Full handshake and stores them in a small FIFO.
- Computes the XY output port for the head packet and presents it to the router switch allocator over a second Req/Gnt handshake.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/xy_route_compute.sv | 34 +++
 rtl/local_input_fifo.sv | 121 ++++++++++++
 tb/tb_local_input_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field positions, one-hot output port codes
// and the input-buffer output FSM encoding.
package noc_pkg;

  localparam int XDST_HI  = 30;
  localparam int XDST_LO  = 28;
  localparam int YDST_HI  = 26;
  localparam int YDST_LO  = 24;
  localparam int PKTID_HI = 15;
  localparam int PKTID_LO = 6;
  localparam int MODID_HI = 5;
  localparam int MODID_LO = 0;

  localparam logic [4:0] PORT_L = 5'b10000;
  localparam logic [4:0] PORT_N = 5'b01000;
  localparam logic [4:0] PORT_E = 5'b00100;
  localparam logic [4:0] PORT_S = 5'b00010;
  localparam logic [4:0] PORT_W = 5'b00001;

  typedef enum logic [1:0] {
    O_IDLE = 2'b00,
    O_REQ  = 2'b01,
    O_GAP  = 2'b10
  } o_state_t;

endpackage

// File: rtl/xy_route_compute.sv
// Dimension-ordered XY route for one packet: resolve X first, then Y,
// otherwise deliver locally. Shared by every router input port.
module xy_route_compute
  import noc_pkg::*;
#(
  parameter logic [5:0] routerID  = 6'b000_000,
  parameter int         dataWidth = 32
) (
  input  logic [dataWidth-1:0] packet,
  output logic [4:0]           PortSel
);

  localparam logic [2:0] XR = routerID[5:3];
  localparam logic [2:0] YR = routerID[2:0];

  logic [2:0] w_xd;
  logic [2:0] w_yd;
  logic       w_unused;

  // The direction bits [31] and [27] and the payload fields play no part in routing.
  assign w_xd     = packet[XDST_HI:XDST_LO];
  assign w_yd     = packet[YDST_HI:YDST_LO];
  assign w_unused = ^{packet[dataWidth-1], packet[27], packet[23:0]};

  always_comb begin
    // NOTE: default assigned first so every path drives PortSel and no latch is inferred.
    PortSel = PORT_L;
    if (w_xd > XR)      PortSel = PORT_E;
    else if (w_xd < XR) PortSel = PORT_W;
    else if (w_yd > YR) PortSel = PORT_N;
    else if (w_yd < YR) PortSel = PORT_S;
  end

endmodule

// File: rtl/local_input_fifo.sv
// Router local-port input buffer: Req/Gnt/Full write side, FIFO, and a
// Req/Gnt head-of-line request to the switch allocator. Define
// LOCAL_FIFO_LOG_EN to log every write and pop.
module local_input_fifo
  import noc_pkg::*;
#(
  parameter logic [5:0] routerID  = 6'b000_000,
  parameter int         dataWidth = 32,
  parameter int         DEPTH     = 4,
  parameter int         addrWidth = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqUpStr,
  output logic                 GntUpStr,
  output logic                 Full,
  input  logic [dataWidth-1:0] PacketIn,
  output logic                 ReqDnStr,
  input  logic                 GntDnStr,
  output logic [dataWidth-1:0] PacketOut,
  output logic [4:0]           PortSel
);

  localparam logic [addrWidth:0] DEPTH_C = (addrWidth + 1)'(DEPTH);

  logic [dataWidth-1:0] r_mem [DEPTH];
  logic [addrWidth-1:0] r_wr_ptr;
  logic [addrWidth-1:0] r_rd_ptr;
  logic [addrWidth:0]   r_count;
  logic                 r_gnt;
  logic                 r_full;
  o_state_t             r_state;
  o_state_t             w_state_nxt;
  logic [addrWidth:0]   w_count_nxt;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [4:0]           w_route;

  // The grant cycle blocks a repeat write while the injector still holds its request.
  assign w_wr_en = ReqUpStr && !r_gnt && (r_count < DEPTH_C);
  assign w_rd_en = (r_state == O_REQ) && GntDnStr;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: packet storage has no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= PacketIn;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_gnt    <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_gnt   <= w_wr_en;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= O_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      O_IDLE:  if (r_count != '0) w_state_nxt = O_REQ;
      O_REQ:   if (GntDnStr) w_state_nxt = O_GAP;
      O_GAP:   w_state_nxt = (r_count != '0) ? O_REQ : O_IDLE;
      default: w_state_nxt = O_IDLE;
    endcase
  end

  xy_route_compute #(
    .routerID (routerID),
    .dataWidth(dataWidth)
  ) u_route (
    .packet (PacketOut),
    .PortSel(w_route)
  );

  assign GntUpStr  = r_gnt;
  assign Full      = r_full;
  assign ReqDnStr  = (r_state == O_REQ);
  assign PacketOut = r_mem[r_rd_ptr];
  assign PortSel   = ReqDnStr ? w_route : 5'b00000;

`ifdef LOCAL_FIFO_LOG_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cycle <= '0;
    else        r_cycle <= r_cycle + 1'b1;
  end

  always @(posedge clk) begin
    if (reset && w_wr_en)
      $display("%0t; %0d; %b; %0d; W; %0d", $time, r_cycle, routerID,
               PacketIn[PKTID_HI:PKTID_LO], w_count_nxt);
    if (reset && w_rd_en)
      $display("%0t; %0d; %b; %0d; R; %0d", $time, r_cycle, routerID,
               PacketOut[PKTID_HI:PKTID_LO], w_count_nxt);
  end
`endif

endmodule

// File: tb/tb_local_input_fifo.sv
// Self-checking bench: two instances (routerID 000_000 and 010_010) driven in
// lockstep, a packet scoreboard, a routing vector table and handshake corner cases.
module tb_local_input_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ReqUpStr = 1'b0;
  logic        GntDnStr = 1'b0;
  logic [31:0] PacketIn = '0;

  logic        GntUpStr, Full, ReqDnStr;
  logic [31:0] PacketOut;
  logic [4:0]  PortSel;
  logic        GntUpStr_b, Full_b, ReqDnStr_b;
  logic [31:0] PacketOut_b;
  logic [4:0]  PortSel_b;

  local_input_fifo #(.routerID(6'b000_000)) dut (
    .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .GntUpStr(GntUpStr), .Full(Full),
    .PacketIn(PacketIn), .ReqDnStr(ReqDnStr), .GntDnStr(GntDnStr),
    .PacketOut(PacketOut), .PortSel(PortSel)
  );

  local_input_fifo #(.routerID(6'b010_010)) dut_b (
    .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .GntUpStr(GntUpStr_b), .Full(Full_b),
    .PacketIn(PacketIn), .ReqDnStr(ReqDnStr_b), .GntDnStr(GntDnStr),
    .PacketOut(PacketOut_b), .PortSel(PortSel_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pkt;
    logic [4:0]  exp_a;
    logic [4:0]  exp_b;
  } vec_t;

  vec_t        vecs [8];
  int          n_total = 0;
  int          n_bad = 0;
  int          gnt_pulses = 0;
  int          pops = 0;
  logic [31:0] sb_q [$];
  logic [9:0]  out_ids [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] route_model(input logic [31:0] p, input logic [5:0] rid);
    logic [2:0] xd;
    logic [2:0] yd;
    xd = p[30:28];
    yd = p[26:24];
    if (xd > rid[5:3]) return 5'b00100;
    if (xd < rid[5:3]) return 5'b00001;
    if (yd > rid[2:0]) return 5'b01000;
    if (yd < rid[2:0]) return 5'b00010;
    return 5'b10000;
  endfunction

  // Scoreboard: accepted packets are queued on grant and compared at each pop.
  always @(negedge clk) begin
    if (reset) begin
      if (GntUpStr) begin
        gnt_pulses++;
        sb_q.push_back(PacketIn);
      end
      if (ReqDnStr && GntDnStr) begin
        pops++;
        out_ids.push_back(PacketOut[15:6]);
        if (sb_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL sb_unexpected_pop: got %h want none", PacketOut);
        end else begin
          logic [31:0] exp;
          exp = sb_q.pop_front();
          check("sb_packet", PacketOut, exp);
          check("sb_packet_b", PacketOut_b, exp);
          check("sb_portsel", {27'd0, PortSel}, {27'd0, route_model(exp, 6'b000_000)});
          check("sb_portsel_b", {27'd0, PortSel_b}, {27'd0, route_model(exp, 6'b010_010)});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] p);
    ReqUpStr = 1'b1;
    PacketIn = p;
    for (int i = 0; i < 40; i++) begin
      step();
      if (GntUpStr) break;
    end
    check("send_grant", {31'd0, GntUpStr}, 32'd1);
    step();
    ReqUpStr = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40; i++) begin
      if (ReqDnStr) break;
      step();
    end
    check("req_wait", {31'd0, ReqDnStr}, 32'd1);
  endtask

  task automatic drain(input int exp_pops);
    int p0;
    p0 = pops;
    GntDnStr = 1'b1;
    for (int i = 0; i < 100 && (pops - p0) < exp_pops; i++) step();
    GntDnStr = 1'b0;
    step(3);
    check("drain_pops", pops - p0, exp_pops);
    check("drain_req_low", {31'd0, ReqDnStr}, 32'd0);
    check("drain_portsel_zero", {27'd0, PortSel}, 32'd0);
  endtask

  initial begin
    int g0;
    int p0;

    vecs[0] = '{32'hA100_0040, 5'b00100, 5'b00010};
    vecs[1] = '{32'h0300_0080, 5'b01000, 5'b00001};
    vecs[2] = '{32'h0000_00C0, 5'b10000, 5'b00001};
    vecs[3] = '{32'h9200_0100, 5'b00100, 5'b00001};
    vecs[4] = '{32'h2200_0140, 5'b00100, 5'b10000};
    vecs[5] = '{32'h8A00_0180, 5'b01000, 5'b00001};
    vecs[6] = '{32'h2500_01C0, 5'b00100, 5'b01000};
    vecs[7] = '{32'h3000_0200, 5'b00100, 5'b00100};

    // Reset held with a pending request: nothing may be granted.
    ReqUpStr = 1'b1;
    PacketIn = 32'hA100_0040;
    step(3);
    check("rst_gnt", {31'd0, GntUpStr}, 32'd0);
    check("rst_full", {31'd0, Full}, 32'd0);
    check("rst_req", {31'd0, ReqDnStr}, 32'd0);
    check("rst_portsel", {27'd0, PortSel}, 32'd0);

    // Single packet: one grant pulse, request one cycle later, routed East.
    reset = 1'b1;
    step();
    check("single_gnt", {31'd0, GntUpStr}, 32'd1);
    check("single_req_not_yet", {31'd0, ReqDnStr}, 32'd0);
    step();
    check("single_gnt_pulse", {31'd0, GntUpStr}, 32'd0);
    check("single_req", {31'd0, ReqDnStr}, 32'd1);
    check("single_pkt", PacketOut, 32'hA100_0040);
    check("single_port", {27'd0, PortSel}, 32'h04);
    ReqUpStr = 1'b0;
    step(2);
    check("single_one_grant", gnt_pulses, 1);
    drain(1);

    // Routing vectors on both router positions.
    foreach (vecs[k]) begin
      send(vecs[k].pkt);
      wait_req();
      check("route_a", {27'd0, PortSel}, {27'd0, vecs[k].exp_a});
      check("route_b", {27'd0, PortSel_b}, {27'd0, vecs[k].exp_b});
      drain(1);
    end

    // Fill to full, refuse a fifth write, pop one, then grant the fifth.
    for (int k = 0; k < 4; k++) begin
      send(32'h1000_0000 | (32'(k + 1) << 6));
      if (k < 3) check("fill_not_full", {31'd0, Full}, 32'd0);
    end
    check("fill_full", {31'd0, Full}, 32'd1);
    check("fill_full_b", {31'd0, Full_b}, 32'd1);
    g0 = gnt_pulses;
    ReqUpStr = 1'b1;
    PacketIn = 32'h1000_0140;
    step(3);
    check("full_refuse", gnt_pulses - g0, 0);
    check("full_refuse_gnt", {31'd0, GntUpStr}, 32'd0);
    GntDnStr = 1'b1;
    step();
    GntDnStr = 1'b0;
    check("pop_clears_full", {31'd0, Full}, 32'd0);
    check("pop_edge_no_gnt", {31'd0, GntUpStr}, 32'd0);
    step();
    check("fifth_gnt", {31'd0, GntUpStr}, 32'd1);
    check("refull", {31'd0, Full}, 32'd1);
    step();
    ReqUpStr = 1'b0;
    drain(4);

    // Simultaneous write and pop with two entries stored.
    send(32'h0000_0040);
    send(32'h0000_0080);
    wait_req();
    ReqUpStr = 1'b1;
    PacketIn = 32'h0000_00C0;
    GntDnStr = 1'b1;
    step();
    GntDnStr = 1'b0;
    check("simul_gnt", {31'd0, GntUpStr}, 32'd1);
    check("simul_gap", {31'd0, ReqDnStr}, 32'd0);
    step();
    ReqUpStr = 1'b0;
    check("simul_req_back", {31'd0, ReqDnStr}, 32'd1);
    check("simul_not_full", {31'd0, Full}, 32'd0);
    drain(2);

    // Streaming: IDs 1..6 leave in order while the allocator keeps granting.
    out_ids.delete();
    p0 = pops;
    fork
      begin
        for (int id = 1; id <= 6; id++) send(32'h0000_0000 | (32'(id) << 6));
      end
      begin
        GntDnStr = 1'b1;
        for (int i = 0; i < 300 && (pops - p0) < 6; i++) step();
        GntDnStr = 1'b0;
      end
    join
    step(3);
    check("stream_pops", pops - p0, 6);
    for (int i = 0; i < 6; i++) begin
      check("stream_id", (i < out_ids.size()) ? {22'd0, out_ids[i]} : 32'hFFFF_FFFF, i + 1);
    end

    // Reset mid-operation: request and Full drop at once, nothing stale afterwards.
    for (int k = 0; k < 4; k++) send(32'h3300_0000 | (32'(k + 8) << 6));
    wait_req();
    check("pre_rst_full", {31'd0, Full}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_req", {31'd0, ReqDnStr}, 32'd0);
    check("async_rst_full", {31'd0, Full}, 32'd0);
    check("async_rst_portsel", {27'd0, PortSel}, 32'd0);
    sb_q.delete();
    step(2);
    reset = 1'b1;
    p0 = pops;
    GntDnStr = 1'b1;
    step(6);
    GntDnStr = 1'b0;
    check("post_rst_no_stale", pops - p0, 0);
    check("post_rst_req", {31'd0, ReqDnStr}, 32'd0);
    send(32'h0100_0400);
    wait_req();
    check("post_rst_pkt", PacketOut, 32'h0100_0400);
    check("post_rst_port", {27'd0, PortSel}, 32'h08);
    drain(1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
